// File: rtl/clk_lock_sequencer.sv
// Supervisor for a PLL/MMCM: pulses the PLL reset, waits for lock with bounded
// retries, then releases the downstream domain resets one at a time.
module clk_lock_sequencer #(
  parameter int NUM_DOMAINS         = 4,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_pll_locked,
  input  logic                   i_restart,
  output logic                   o_pll_reset,
  output logic [NUM_DOMAINS-1:0] o_domain_rst_n,
  output logic                   o_ready,
  output logic                   o_fail,
  output logic [RW-1:0]          o_retry_count,
  output logic [2:0]             o_state
);

  // One counter serves the pulse, the lock timeout and the stagger interval.
  localparam int MAX_A   = (RST_PULSE_CYCLES > STAGGER_CYCLES) ? RST_PULSE_CYCLES : STAGGER_CYCLES;
  localparam int CNT_LEN = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_LEN);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d, dom_shift;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic                   pll_reset_q, pll_reset_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_pll_locked};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dom_d     = dom_q;
    retry_d   = retry_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    dom_shift = (dom_q << 1) | NUM_DOMAINS'(1);
    if (i_restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      dom_d   = '0;
      retry_d = '0;
      ready_d = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q < RW'(MAX_RETRIES)) begin
              retry_d = retry_q + RW'(1);
              state_d = RESET_PLL;
            end else begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            dom_d   = '0;
            ready_d = 1'b0;
          end else if (state_q == RELEASE) begin
            if (cnt_q == STAGGER_LAST) begin
              cnt_d = '0;
              dom_d = dom_shift;
              // Releasing the top domain completes the sequence on the same edge.
              if (dom_shift[NUM_DOMAINS-1]) begin
                state_d = RUN;
                ready_d = 1'b1;
                retry_d = '0;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FAIL: ;
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          dom_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAIL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      dom_q       <= '0;
      retry_q     <= '0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dom_q       <= dom_d;
      retry_q     <= retry_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      pll_reset_q <= pll_reset_d;
      sync_q      <= sync_d;
    end
  end

  assign o_pll_reset    = pll_reset_q;
  assign o_domain_rst_n = dom_q;
  assign o_ready        = ready_q;
  assign o_fail         = fail_q;
  assign o_retry_count  = retry_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Scoreboard bench for clk_lock_sequencer: a phase/elapsed-time reference model
// predicts every cycle's outputs; a monitor process pops and compares them.
module tb_clk_lock_sequencer;

  localparam int ND    = 4;
  localparam int PULSE = 16;
  localparam int TMO   = 64;
  localparam int STAG  = 8;
  localparam int MAXR  = 3;
  localparam int SYNC  = 2;
  localparam int RW    = $clog2(MAXR + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          restart = 1'b0;
  logic          pll_reset;
  logic [ND-1:0] dom_rst_n;
  logic          ready;
  logic          fail;
  logic [RW-1:0] retry_count;
  logic [2:0]    state;

  clk_lock_sequencer #(
    .NUM_DOMAINS        (ND),
    .RST_PULSE_CYCLES   (PULSE),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .STAGGER_CYCLES     (STAG),
    .MAX_RETRIES        (MAXR),
    .SYNC_STAGES        (SYNC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pll_locked  (pll_locked),
    .i_restart     (restart),
    .o_pll_reset   (pll_reset),
    .o_domain_rst_n(dom_rst_n),
    .o_ready       (ready),
    .o_fail        (fail),
    .o_retry_count (retry_count),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          pr;
    logic [ND-1:0] dom;
    logic          rdy;
    logic          fl;
    logic [RW-1:0] rc;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase number, edge of phase entry, domains released so far.
  localparam int P_RESET = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3, P_FAIL = 4;
  int m_k, m_ph, m_entry, m_nrel, m_retr;
  bit m_rdy, m_fl;
  bit m_hist[$];

  function automatic void mdl_reset();
    m_ph = P_RESET; m_entry = m_k; m_nrel = 0; m_retr = 0; m_rdy = 0; m_fl = 0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void mdl_step(bit lk, bit rs);
    bit ls;
    int el;
    m_k++;
    ls = m_hist.pop_front();
    m_hist.push_back(lk);
    el = m_k - m_entry;
    if (rs) begin
      m_ph = P_RESET; m_entry = m_k; m_nrel = 0; m_retr = 0; m_rdy = 0; m_fl = 0;
    end else begin
      case (m_ph)
        P_RESET: if (el == PULSE) begin m_ph = P_WAIT; m_entry = m_k; end
        P_WAIT: begin
          if (ls) begin
            m_ph = P_REL; m_entry = m_k;
          end else if (el == TMO) begin
            if (m_retr < MAXR) begin m_retr++; m_ph = P_RESET; m_entry = m_k; end
            else begin m_ph = P_FAIL; m_fl = 1; end
          end
        end
        P_REL, P_RUN: begin
          if (!ls) begin
            m_ph = P_RESET; m_entry = m_k; m_nrel = 0; m_rdy = 0;
          end else if (m_ph == P_REL) begin
            m_nrel = el / STAG;
            if (m_nrel >= ND) begin m_nrel = ND; m_ph = P_RUN; m_rdy = 1; m_retr = 0; end
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic obs_t mdl_out();
    obs_t o;
    o.st  = 3'(m_ph);
    o.pr  = (m_ph == P_RESET) || (m_ph == P_FAIL);
    o.dom = ND'((1 << m_nrel) - 1);
    o.rdy = m_rdy;
    o.fl  = m_fl;
    o.rc  = RW'(m_retr);
    return o;
  endfunction

  // Monitor: every active cycle is an output beat.
  initial begin
    obs_t e, a;
    int cyc_no = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{st: state, pr: pll_reset, dom: dom_rst_n, rdy: ready, fl: fail, rc: retry_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL sb t=%0d: got st=%0d pr=%0b dom=%b rdy=%0b fail=%0b rc=%0d, expected st=%0d pr=%0b dom=%b rdy=%0b fail=%0b rc=%0d",
                   cyc_no, a.st, a.pr, a.dom, a.rdy, a.fl, a.rc, e.st, e.pr, e.dom, e.rdy, e.fl, e.rc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, predict, wait to the next negedge.
  task automatic cyc(input bit lk, input bit rs);
    pll_locked = lk;
    restart    = rs;
    mdl_step(lk, rs);
    sb_q.push_back(mdl_out());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    restart = 1'b0;
    #1;
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_dom", dom_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_state", state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, frel, fpr, pulses, found;
    bit prev, lk;
    int hold;
    m_k = 0;
    mdl_reset();
    repeat (2) @(negedge clk);

    // Lock arrives at cycle 30: release at 33, domains at 41/49/57/65.
    do_reset();
    fr = -1; frel = -1; fpr = -1;
    for (int n = 0; n < 75; n++) begin
      cyc(n >= 30, 1'b0);
      if (!pll_reset && fpr < 0) fpr = n + 1;
      if (state == 3'd2 && frel < 0) frel = n + 1;
      if (ready && fr < 0) fr = n + 1;
    end
    chk("s1_pll_reset_low_cycle", fpr, 16);
    chk("s1_release_cycle", frel, 33);
    chk("s1_ready_cycle", fr, 65);
    chk("s1_state_run", state, 3);
    chk("s1_all_released", dom_rst_n, 15);

    // No lock ever: four attempts, then FAIL with the PLL held in reset.
    do_reset();
    pulses = 1; prev = 1'b1;
    for (int n = 0; n < 330; n++) begin
      cyc(1'b0, 1'b0);
      if (pll_reset && !prev && !fail) pulses++;
      prev = pll_reset;
    end
    chk("s2_pulses", pulses, 4);
    chk("s2_fail", fail, 1);
    chk("s2_state_fail", state, 4);
    chk("s2_pll_reset_held", pll_reset, 1);
    chk("s2_retry", retry_count, 3);

    // Restart out of FAIL with lock present.
    cyc(1'b1, 1'b1);
    chk("s5_fail_cleared", fail, 0);
    chk("s5_retry_cleared", retry_count, 0);
    chk("s5_state_reset", state, 0);
    for (int n = 0; n < 80; n++) cyc(1'b1, 1'b0);
    chk("s5_run_again", state, 3);

    // Lock loss in RUN: domains drop three cycles after the drop.
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s3_still_released", dom_rst_n, 15);
    cyc(1'b0, 1'b0);
    chk("s3_dom_dropped", dom_rst_n, 0);
    chk("s3_ready_dropped", ready, 0);
    chk("s3_pll_reset", pll_reset, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int n = 0; n < 80; n++) cyc(1'b1, 1'b0);
    chk("s3_resequenced", state, 3);

    // One timeout, then lock lost after two domains released.
    do_reset();
    hold = 80 + int'($urandom_range(0, 10));
    for (int n = 0; n < hold; n++) cyc(1'b0, 1'b0);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      cyc(1'b1, 1'b0);
      if (dom_rst_n == 4'b0011) found = 1;
    end
    chk("s4_two_released", found, 1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("s4_dom_dropped", dom_rst_n, 0);
    chk("s4_retry_kept", retry_count, 1);
    chk("s4_state_reset", state, 0);
    for (int n = 0; n < 60; n++) cyc(1'b1, 1'b0);
    chk("s4_run", state, 3);
    chk("s4_retry_run", retry_count, 0);

    // Restart on the final timeout edge beats FAIL.
    do_reset();
    for (int n = 0; n < 319; n++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("s6_state_reset", state, 0);
    chk("s6_retry", retry_count, 0);
    chk("s6_fail", fail, 0);
    for (int n = 0; n < 40; n++) cyc(1'b1, 1'b0);

    // Random lock behaviour with occasional restarts and one async reset.
    lk = 1'b1; hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        lk   = ($urandom_range(0, 3) != 0);
        hold = lk ? int'($urandom_range(10, 120)) : int'($urandom_range(1, 90));
      end
      hold--;
      if (n == 700) do_reset();
      cyc(lk, $urandom_range(0, 299) == 0);
    end

    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
